// File: rtl/nway_queue.sv
// N-way circular FIFO: up to WAYS enqueues and WAYS dequeues per cycle, count-based handshakes.
// Optional high-water-mark tracking is enabled by defining QUEUE_HWM_EN.
module nway_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WAYS  = 4,
  localparam int unsigned CW   = $clog2(WAYS + 1),
  localparam int unsigned OW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [CW-1:0]         enq_cnt,
  input  logic [WAYS*WIDTH-1:0] enq_data,
  output logic [CW-1:0]         enq_acc,
  input  logic [CW-1:0]         deq_cnt,
  output logic [CW-1:0]         deq_acc,
  output logic [WAYS*WIDTH-1:0] deq_data,
  output logic [CW-1:0]         deq_avail,
  output logic [OW-1:0]         free_slots,
  output logic [OW-1:0]         occupancy,
  output logic                  empty,
  output logic                  full,
  input  logic                  hwm_clr,
  output logic [OW-1:0]         hwm
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   ptr_sum_t;

  // One extra bit holds ptr + offset (< 2*DEPTH); a single compare-and-subtract
  // wraps it, which stays correct for non-power-of-two DEPTH.
  function automatic ptr_t wrap(input ptr_sum_t v);
    if (v >= ptr_sum_t'(DEPTH)) begin
      return ptr_t'(v - ptr_sum_t'(DEPTH));
    end
    return ptr_t'(v);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic [OW-1:0] count_q, count_d;

  logic [CW-1:0] enq_req;
  logic [CW-1:0] deq_req;
  logic [OW-1:0] space;
  ptr_t          wr_idx [WAYS];
  ptr_t          rd_idx [WAYS];
  logic [WAYS-1:0] wr_en;

  always_comb begin
    enq_req = (enq_cnt > CW'(WAYS)) ? CW'(WAYS) : enq_cnt;
    deq_req = (deq_cnt > CW'(WAYS)) ? CW'(WAYS) : deq_cnt;
  end

  // Dequeue grant feeds the enqueue grant: slots freed this cycle are reusable.
  always_comb begin
    deq_acc = '0;
    enq_acc = '0;
    space   = '0;
    if (!flush) begin
      deq_acc = (OW'(deq_req) > count_q) ? CW'(count_q) : deq_req;
      space   = OW'(DEPTH) - count_q + OW'(deq_acc);
      enq_acc = (OW'(enq_req) > space) ? CW'(space) : enq_req;
    end
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      wr_idx[i] = wrap(ptr_sum_t'(tail_q) + ptr_sum_t'(i));
      rd_idx[i] = wrap(ptr_sum_t'(head_q) + ptr_sum_t'(i));
      wr_en[i]  = (CW'(i) < enq_acc);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = wrap(ptr_sum_t'(head_q) + ptr_sum_t'(deq_acc));
      tail_d  = wrap(ptr_sum_t'(tail_q) + ptr_sum_t'(enq_acc));
      count_d = count_q - OW'(deq_acc) + OW'(enq_acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; wr_en is already zero during flush.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= enq_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    deq_data = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      deq_data[i*WIDTH +: WIDTH] = mem_q[rd_idx[i]];
    end
  end

  always_comb begin
    deq_avail  = (count_q > OW'(WAYS)) ? CW'(WAYS) : CW'(count_q);
    free_slots = OW'(DEPTH) - count_q;
    occupancy  = count_q;
    empty      = (count_q == '0);
    full       = (count_q == OW'(DEPTH));
  end

`ifdef QUEUE_HWM_EN
  logic [OW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = hwm_clr;
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_nway_queue.sv
// Scoreboard bench for nway_queue: a 16-deep and a 6-deep instance, directed vectors.
// The hwm expectations follow QUEUE_HWM_EN when the bundle is built with it.
module tb_nway_queue;

`ifdef QUEUE_HWM_EN
  localparam bit HWM_ON = 1'b1;
`else
  localparam bit HWM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-deep instance
  logic         flush16 = 1'b0;
  logic [2:0]   enq16 = '0, deqc16 = '0;
  logic [127:0] enqd16 = '0;
  logic [2:0]   enqacc16, deqacc16, avail16;
  logic [127:0] deqd16;
  logic [4:0]   free16, occ16, hwm16;
  logic         empty16, full16;
  logic         hwmclr16 = 1'b0;

  // 6-deep instance
  logic         flush6 = 1'b0;
  logic [2:0]   enq6 = '0, deqc6 = '0;
  logic [127:0] enqd6 = '0;
  logic [2:0]   enqacc6, deqacc6, avail6;
  logic [127:0] deqd6;
  logic [2:0]   free6, occ6, hwm6;
  logic         empty6, full6;
  logic         hwmclr6 = 1'b0;

  nway_queue #(.WIDTH(32), .DEPTH(16), .WAYS(4)) u16 (
    .clk(clk), .rst(rst), .flush(flush16),
    .enq_cnt(enq16), .enq_data(enqd16), .enq_acc(enqacc16),
    .deq_cnt(deqc16), .deq_acc(deqacc16), .deq_data(deqd16),
    .deq_avail(avail16), .free_slots(free16), .occupancy(occ16),
    .empty(empty16), .full(full16), .hwm_clr(hwmclr16), .hwm(hwm16)
  );

  nway_queue #(.WIDTH(32), .DEPTH(6), .WAYS(4)) u6 (
    .clk(clk), .rst(rst), .flush(flush6),
    .enq_cnt(enq6), .enq_data(enqd6), .enq_acc(enqacc6),
    .deq_cnt(deqc6), .deq_acc(deqacc6), .deq_data(deqd6),
    .deq_avail(avail6), .free_slots(free6), .occupancy(occ6),
    .empty(empty6), .full(full6), .hwm_clr(hwmclr6), .hwm(hwm6)
  );

  typedef struct {
    int unsigned enq;
    int unsigned deq;
    int unsigned occ;
    bit          flush;
  } rec_t;

  rec_t        r16 [$];
  rec_t        r6  [$];
  logic [31:0] d16 [$];
  logic [31:0] d6  [$];
  logic [31:0] nv16 = 32'hA0;
  logic [31:0] nv6  = 32'h60;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned min4(input int unsigned v);
    return (v > 4) ? 4 : v;
  endfunction

  task automatic cyc16(input int en, input int dn, input bit fl, input bit hc,
                       input int e_enq, input int e_deq, input int e_occ);
    rec_t r;
    @(posedge clk); #1;
    enq16    = 3'(en);
    deqc16   = 3'(dn);
    flush16  = fl;
    hwmclr16 = hc;
    for (int i = 0; i < 4; i++) enqd16[i*32 +: 32] = nv16 + 32'(i);
    for (int i = 0; i < e_enq; i++) d16.push_back(nv16 + 32'(i));
    nv16 = nv16 + 32'(e_enq);
    r.enq = e_enq; r.deq = e_deq; r.occ = e_occ; r.flush = fl;
    r16.push_back(r);
  endtask

  task automatic cyc6(input int en, input int dn, input int e_enq, input int e_deq, input int e_occ);
    rec_t r;
    @(posedge clk); #1;
    enq6  = 3'(en);
    deqc6 = 3'(dn);
    for (int i = 0; i < 4; i++) enqd6[i*32 +: 32] = nv6 + 32'(i);
    for (int i = 0; i < e_enq; i++) d6.push_back(nv6 + 32'(i));
    nv6 = nv6 + 32'(e_enq);
    r.enq = e_enq; r.deq = e_deq; r.occ = e_occ; r.flush = 1'b0;
    r6.push_back(r);
  endtask

  task automatic chk_neg(input string nm, input logic [63:0] act_unused, input logic [63:0] exp);
    @(negedge clk);
    chk(nm, {59'd0, hwm16}, exp);
  endtask

  // Monitor: pops one expected record per presented cycle and compares outputs.
  always @(negedge clk) begin
    rec_t r;
    if (r16.size() > 0) begin
      r = r16.pop_front();
      chk("q16 enq_acc", enqacc16, r.enq);
      chk("q16 deq_acc", deqacc16, r.deq);
      chk("q16 occupancy", occ16, r.occ);
      chk("q16 deq_avail", avail16, min4(r.occ));
      chk("q16 free_slots", free16, 16 - r.occ);
      chk("q16 full", full16, r.occ == 16);
      chk("q16 empty", empty16, r.occ == 0);
      for (int i = 0; i < int'(min4(r.occ)); i++)
        chk($sformatf("q16 lane%0d", i), deqd16[i*32 +: 32], d16[i]);
      for (int i = 0; i < int'(r.deq); i++)
        if (d16.size() > 0) void'(d16.pop_front());
      if (r.flush) d16.delete();
    end
    if (r6.size() > 0) begin
      r = r6.pop_front();
      chk("q6 enq_acc", enqacc6, r.enq);
      chk("q6 deq_acc", deqacc6, r.deq);
      chk("q6 occupancy", occ6, r.occ);
      chk("q6 deq_avail", avail6, min4(r.occ));
      chk("q6 full", full6, r.occ == 6);
      for (int i = 0; i < int'(min4(r.occ)); i++)
        chk($sformatf("q6 lane%0d", i), deqd6[i*32 +: 32], d6[i]);
      for (int i = 0; i < int'(r.deq); i++)
        if (d6.size() > 0) void'(d6.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst empty", empty16, 1);
    chk("rst full", full16, 0);
    chk("rst occupancy", occ16, 0);
    chk("rst free_slots", free16, 16);
    chk("rst deq_avail", avail16, 0);
    chk("rst enq_acc", enqacc16, 0);
    chk("rst deq_acc", deqacc16, 0);
    chk("rst hwm", hwm16, 0);
    chk("rst q6 free_slots", free6, 6);
    @(posedge clk); #1;
    rst = 1'b0;

    // 6-deep: alternate enq 4 / deq 4; pointers step 0,4,2,0,... across the wrap
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) cyc6(4, 0, 4, 0, 0);
      else            cyc6(0, 4, 0, 4, 4);
    end
    cyc6(0, 0, 0, 0, 0);

    // 16-deep: en, dn, flush, hwm_clr, exp enq_acc, exp deq_acc, occupancy
    cyc16(4, 0, 0, 0, 4, 0, 0);
    cyc16(0, 0, 0, 0, 0, 0, 4);
    cyc16(4, 0, 0, 0, 4, 0, 4);
    cyc16(4, 0, 0, 0, 4, 0, 8);
    cyc16(4, 0, 0, 0, 4, 0, 12);
    cyc16(4, 2, 0, 0, 2, 2, 16);
    cyc16(4, 0, 0, 0, 0, 0, 16);
    cyc16(0, 4, 0, 0, 0, 4, 16);
    cyc16(0, 4, 0, 0, 0, 4, 12);
    cyc16(0, 4, 0, 0, 0, 4, 8);
    cyc16(0, 3, 0, 0, 0, 3, 4);
    cyc16(0, 3, 0, 0, 0, 1, 1);
    cyc16(2, 2, 0, 0, 2, 0, 0);
    cyc16(7, 7, 0, 0, 4, 2, 2);
    cyc16(4, 0, 0, 0, 4, 0, 4);
    cyc16(1, 0, 0, 0, 1, 0, 8);
    cyc16(4, 4, 1, 0, 0, 0, 9);
    cyc16(4, 0, 0, 0, 4, 0, 0);
    cyc16(0, 0, 0, 0, 0, 0, 4);

    // Reset mid-burst, observed before the next clock edge
    @(posedge clk); #1;
    enq16 = 3'd4;
    deqc16 = 3'd0;
    #2 rst = 1'b1;
    #1;
    chk("async rst empty", empty16, 1);
    chk("async rst occupancy", occ16, 0);
    chk("async rst free_slots", free16, 16);
    enq16 = '0;
    d16.delete();
    d6.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc16(0, 0, 0, 0, 0, 0, 0);

    // High-water mark: fill to 11, drain to 3, clear, refill to 5, flush
    cyc16(4, 0, 0, 0, 4, 0, 0);
    cyc16(4, 0, 0, 0, 4, 0, 4);
    cyc16(3, 0, 0, 0, 3, 0, 8);
    cyc16(0, 4, 0, 0, 0, 4, 11);
    cyc16(0, 4, 0, 0, 0, 4, 7);
    cyc16(0, 0, 0, 0, 0, 0, 3);
    chk_neg("hwm after drain", 64'd0, HWM_ON ? 11 : 0);
    cyc16(0, 0, 0, 1, 0, 0, 3);
    cyc16(2, 0, 0, 0, 2, 0, 3);
    chk_neg("hwm after clear", 64'd0, HWM_ON ? 3 : 0);
    cyc16(0, 0, 0, 0, 0, 0, 5);
    chk_neg("hwm after refill", 64'd0, HWM_ON ? 5 : 0);
    cyc16(0, 0, 1, 0, 0, 0, 5);
    cyc16(0, 0, 0, 0, 0, 0, 0);
    chk_neg("hwm kept over flush", 64'd0, HWM_ON ? 5 : 0);

    @(posedge clk); #1;
    enq16 = '0; deqc16 = '0; flush16 = 1'b0; hwmclr16 = 1'b0;
    enq6 = '0; deqc6 = '0;
    for (int k = 0; k < 10 && (r16.size() > 0 || r6.size() > 0); k++) @(negedge clk);
    chk("scoreboard drained", 64'(r16.size() + r6.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nway_queue.md
Name: nway_queue

Overview:
Parametrised N-way circular FIFO that generalises the 2-way superscalar queue to WAYS enqueue and dequeue lanes per cycle. It uses count-based handshakes and supports non-power-of-two DEPTH. An explicit occupancy counter replaces the head==tail valid-flag scheme. It sits between fetch/decode and rename/dispatch, and is usable as the instruction buffer or as any multi-issue staging queue.

Parameters:
WIDTH, 32, bits per entry
DEPTH, 16, number of entries; any value >= 2, not required to be a power of two
WAYS, 4, max enqueues and max dequeues per cycle; 1 <= WAYS <= DEPTH
CW (localparam), $clog2(WAYS+1), width of per-cycle count fields
OW (localparam), $clog2(DEPTH+1), width of occupancy fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of all entries
enq_cnt  in  CW  entries offered this cycle; lanes 0..enq_cnt-1 valid
enq_data  in  WAYS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
enq_acc  out  CW  entries accepted this cycle
deq_cnt  in  CW  entries requested this cycle
deq_acc  out  CW  entries removed this cycle
deq_data  out  WAYS*WIDTH  lane i = entry at head+i (mod DEPTH)
deq_avail  out  CW  min(WAYS, count)
free_slots  out  OW  DEPTH - count
occupancy  out  OW  count
empty  out  1  count == 0
full  out  1  count == DEPTH
hwm_clr  in  1  clears the high-water mark (used only with the optional feature)
hwm  out  OW  high-water mark (optional feature)

Behaviour:
- State: head, tail (each $clog2(DEPTH) bits, range 0..DEPTH-1) and count (OW bits). Storage is not reset.
- Reset: async assert sets head=tail=count=0. Outputs after reset: empty=1, full=0, occupancy=0, free_slots=DEPTH, deq_avail=0, enq_acc=deq_acc=0 (when inputs are 0), hwm=0.
- Input clamping: enq_cnt or deq_cnt values greater than WAYS are treated as WAYS.
- Dequeue: deq_acc = min(deq_cnt, count). This is combinational, same cycle.
- Enqueue: enq_acc = min(enq_cnt, DEPTH - count + deq_acc). Space freed by same-cycle dequeues is usable. This creates a combinational path deq_cnt -> enq_acc.
- Write: for each i < enq_acc, storage[(tail+i) mod DEPTH] <= lane i on the clock edge.
- Pointer update: tail += enq_acc and head += deq_acc, both mod DEPTH. Wrap uses compare-and-subtract, never bit truncation, so non-power-of-two DEPTH is correct.
- Count update: count <= count + enq_acc - deq_acc. count never exceeds DEPTH and never goes below 0.
- Read: deq_data is combinational from head. Lanes at or beyond count carry stale storage and are don't-care. Dequeue latency is 0; an entry is visible the cycle after its enqueue (no write-through bypass).
- Flush: on the next edge head=tail=count=0. Flush has priority over same-cycle enq/deq. enq_acc and deq_acc are forced to 0 while flush=1, and no storage write occurs.
- Reset mid-operation: async and immediate, regardless of pending enq/deq/flush.
- Full with dequeue: at count=DEPTH, deq_cnt=2 and enq_cnt=WAYS gives enq_acc=2. Count stays at DEPTH.
- Empty: deq_acc=0 whatever deq_cnt is. Simultaneous enq into an empty queue does not bypass to deq_data.

Optional Feature:
QUEUE_HWM_EN
- Defined: hwm register (OW bits) reset to 0. Each cycle, hwm <= max(hwm, next count). hwm_clr sets hwm <= next count, with priority over the max update. Flush does not clear hwm.
- Undefined: hwm tied to 0, hwm_clr ignored, no register is inferred.

Test Plan:
- Reset, then enq_cnt=4 with lanes 0xA0..0xA3 -> enq_acc=4. Next cycle: occupancy=4, deq_avail=4, deq_data lanes = 0xA0..0xA3.
- Fill DEPTH=16 entries, then enq_cnt=4 with deq_cnt=2 in the same cycle -> deq_acc=2, enq_acc=2, occupancy stays 16, full=1.
- DEPTH=6, WAYS=4: alternate enq 4 / deq 4 for 10 cycles -> pointers wrap 5->0 correctly and data order is preserved. Scoreboard against a reference model.
- occupancy=1, deq_cnt=3 -> deq_acc=1, empty=1 next cycle. Then deq_cnt=2 while empty -> deq_acc=0.
- occupancy=9, flush=1 with enq_cnt=4 and deq_cnt=4 -> enq_acc=deq_acc=0, occupancy=0 next cycle. Assert rst mid-burst -> empty=1 immediately, without waiting for a clock edge.
- QUEUE_HWM_EN: fill to 11, drain to 3 -> hwm=11. Pulse hwm_clr -> hwm=3. Refill to 5 -> hwm=5.
